// File: rtl/sprite_mover_pkg.sv
// Shared definitions for the sprite demo: screen geometry, 3-bit colour codes,
// FSM state encodings and the saturating X-advance helper.
package snoopy_defs;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    localparam logic [2:0] BLACK   = 3'b000;
    localparam logic [2:0] BLUE    = 3'b001;
    localparam logic [2:0] GREEN   = 3'b010;
    localparam logic [2:0] CYAN    = 3'b011;
    localparam logic [2:0] RED     = 3'b100;
    localparam logic [2:0] MAGENTA = 3'b101;
    localparam logic [2:0] YELLOW  = 3'b110;
    localparam logic [2:0] WHITE   = 3'b111;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_DRAW   = 3'd1;
    localparam logic [2:0] ST_WAIT   = 3'd2;
    localparam logic [2:0] ST_ERASE  = 3'd3;
    localparam logic [2:0] ST_UPDATE = 3'd4;
    localparam logic [2:0] ST_WIN    = 3'd5;
    localparam logic [2:0] ST_LOSE   = 3'd6;

    // The sum is formed in 9 bits so a base near 255 could never wrap before clamping.
    function automatic logic [7:0] sat_step(input logic [7:0] base,
                                            input logic [3:0] step,
                                            input logic [7:0] limit);
        logic [8:0] sum;
        sum = {1'b0, base} + {5'b0, step};
        return (sum > {1'b0, limit}) ? limit : sum[7:0];
    endfunction

endpackage

// File: rtl/sprite_mover_if.sv
// Pixel write port toward the VGA adapter and collision detector, plus the
// sticky detector flags coming back.
interface sprite_mover_if;

    logic [7:0] x_coord;
    logic [6:0] y_coord;
    logic [2:0] colour;
    logic       plot;
    logic       collided;
    logic       reached_screen_end;

    modport master (
        output x_coord, y_coord, colour, plot,
        input  collided, reached_screen_end
    );

    modport slave (
        input  x_coord, y_coord, colour, plot,
        output collided, reached_screen_end
    );

endinterface

// File: rtl/sprite_mover_raster_counter.sv
// Row-major (ox fastest) offset walker over a WxH footprint; shared by the
// draw and erase passes so both touch exactly the same pixels.
module sprite_raster_counter #(
    parameter int W = 4,
    parameter int H = 4
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       clear,
    input  logic       enable,
    output logic [3:0] ox,
    output logic [3:0] oy,
    output logic       last
);

    localparam logic [3:0] OX_MAX = 4'(W - 1);
    localparam logic [3:0] OY_MAX = 4'(H - 1);

    assign last = (ox == OX_MAX) && (oy == OY_MAX);

    // Wraps to the origin after the last pixel so back-to-back passes need no clear.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ox <= '0;
            oy <= '0;
        end else if (clear) begin
            ox <= '0;
            oy <= '0;
        end else if (enable) begin
            if (ox == OX_MAX) begin
                ox <= '0;
                oy <= (oy == OY_MAX) ? 4'd0 : oy + 4'd1;
            end else begin
                ox <= ox + 4'd1;
            end
        end
    end

endmodule

// File: rtl/sprite_mover.sv
// Walks a WxH sprite rightward across the screen: erase, advance, redraw on
// every FRAMES_PER_MOVE frames, stopping in WIN or LOSE on detector flags.
module sprite_mover
    import snoopy_defs::*;
#(
    parameter int         SPRITE_W        = 4,
    parameter int         SPRITE_H        = 4,
    parameter int         X_START         = 0,
    parameter int         Y_START         = 60,
    parameter int         STEP            = 1,
    parameter int         FRAMES_PER_MOVE = 4,
    parameter logic [2:0] SPRITE_COLOUR   = YELLOW,
    parameter logic [2:0] BG_COLOUR       = BLACK
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          start,
    input  logic          frame_tick,
    sprite_mover_if.master pix,
    output logic          done,
    output logic          win,
    output logic          lose
);

    localparam logic [7:0]  X_INIT     = 8'(X_START);
    localparam logic [7:0]  X_MAX      = 8'(SCREEN_W - SPRITE_W);
    localparam logic [6:0]  Y_BASE     = 7'(Y_START);
    localparam logic [3:0]  STEP_V     = 4'(STEP);
    localparam logic [15:0] LAST_FRAME = 16'(FRAMES_PER_MOVE - 1);

    logic [2:0]  state;
    logic [7:0]  base_x;
    logic [15:0] frame_count;
    logic [3:0]  ox;
    logic [3:0]  oy;
    logic        last;
    logic        raster_active;
    logic [7:0]  pix_x;
    logic [6:0]  pix_y;

    assign raster_active = (state == ST_DRAW) || (state == ST_ERASE);
    assign pix_x = base_x + {4'b0, ox};
    assign pix_y = Y_BASE + {3'b0, oy};

    sprite_raster_counter #(
        .W (SPRITE_W),
        .H (SPRITE_H)
    ) u_raster (
        .clock  (clock),
        .resetn (resetn),
        .clear  (!raster_active),
        .enable (raster_active),
        .ox     (ox),
        .oy     (oy),
        .last   (last)
    );

    // plot defaults low each cycle and is only raised while a raster pass is emitting.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state       <= ST_IDLE;
            base_x      <= X_INIT;
            frame_count <= '0;
            pix.x_coord <= '0;
            pix.y_coord <= '0;
            pix.colour  <= BG_COLOUR;
            pix.plot    <= 1'b0;
            done        <= 1'b0;
            win         <= 1'b0;
            lose        <= 1'b0;
        end else begin
            pix.plot <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) state <= ST_DRAW;
                end
                ST_DRAW: begin
                    pix.plot    <= 1'b1;
                    pix.x_coord <= pix_x;
                    pix.y_coord <= pix_y;
                    pix.colour  <= SPRITE_COLOUR;
                    if (last) begin
                        state       <= ST_WAIT;
                        frame_count <= '0;
                    end
                end
                ST_WAIT: begin
                    if (pix.collided) begin
                        state <= ST_LOSE;
                        done  <= 1'b1;
                        lose  <= 1'b1;
                    end else if (pix.reached_screen_end) begin
                        state <= ST_WIN;
                        done  <= 1'b1;
                        win   <= 1'b1;
                    end else if (frame_tick) begin
                        if (frame_count == LAST_FRAME) begin
                            frame_count <= '0;
                            state       <= ST_ERASE;
                        end else begin
                            frame_count <= frame_count + 16'd1;
                        end
                    end
                end
                ST_ERASE: begin
                    pix.plot    <= 1'b1;
                    pix.x_coord <= pix_x;
                    pix.y_coord <= pix_y;
                    pix.colour  <= BG_COLOUR;
                    if (last) state <= ST_UPDATE;
                end
                ST_UPDATE: begin
                    base_x <= sat_step(base_x, STEP_V, X_MAX);
                    state  <= ST_DRAW;
                end
                ST_WIN, ST_LOSE: begin
                    state <= state;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_mover.sv
// Directed bench for sprite_mover with default parameters (4x4 sprite at y=60,
// one pixel per move, four frames per move).
module tb_sprite_mover;

    logic clock = 1'b0;
    logic resetn = 1'b1;
    logic start = 1'b0;
    logic frame_tick = 1'b0;
    logic done;
    logic win;
    logic lose;
    int   checks = 0;
    int   failures = 0;

    sprite_mover_if pix ();

    sprite_mover dut (
        .clock      (clock),
        .resetn     (resetn),
        .start      (start),
        .frame_tick (frame_tick),
        .pix        (pix),
        .done       (done),
        .win        (win),
        .lose       (lose)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic s, input logic ft, input logic col, input logic rse);
        start                  = s;
        frame_tick             = ft;
        pix.collided           = col;
        pix.reached_screen_end = rse;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_plot"}, 32'(pix.plot), 0);
        checkOutput({tag, "_x"}, 32'(pix.x_coord), 0);
        checkOutput({tag, "_y"}, 32'(pix.y_coord), 0);
        checkOutput({tag, "_colour"}, 32'(pix.colour), 0);
        checkOutput({tag, "_done"}, 32'(done), 0);
        checkOutput({tag, "_win"}, 32'(win), 0);
        checkOutput({tag, "_lose"}, 32'(lose), 0);
    endtask

    // One full 4x4 pass, one pixel per clock; noise pulses start/frame_tick mid-pass.
    task automatic checkRaster(input string tag, input int base, input logic [2:0] col, input bit noise);
        for (int oy = 0; oy < 4; oy++) begin
            for (int ox = 0; ox < 4; ox++) begin
                step();
                checkOutput({tag, "_plot"}, 32'(pix.plot), 1);
                checkOutput({tag, "_x"}, 32'(pix.x_coord), 32'(base + ox));
                checkOutput({tag, "_y"}, 32'(pix.y_coord), 32'(60 + oy));
                checkOutput({tag, "_colour"}, 32'(pix.colour), 32'(col));
                if (noise && (oy * 4 + ox) inside {2, 7, 11}) applyStimulus(1, 1, 0, 0);
                else applyStimulus(0, 0, 0, 0);
            end
        end
    endtask

    task automatic doMove(input int old_base, input int new_base, input bit verify);
        applyStimulus(0, 1, 0, 0);
        repeat (4) step();
        applyStimulus(0, 0, 0, 0);
        if (verify) begin
            checkRaster("mv_erase", old_base, 3'b000, 0);
            step();
            checkOutput("mv_update_gap", 32'(pix.plot), 0);
            checkRaster("mv_draw", new_base, 3'b110, 0);
            step();
            checkOutput("mv_wait_plot", 32'(pix.plot), 0);
        end else begin
            repeat (34) step();
        end
    endtask

    initial begin
        applyStimulus(0, 0, 0, 0);
        #3 resetn = 1'b0;
        step();
        step();
        checkReset("reset");
        resetn = 1'b1;
        step();
        checkOutput("idle_plot", 32'(pix.plot), 0);

        $display("[TB] first draw");
        applyStimulus(1, 0, 0, 0);
        step();
        applyStimulus(0, 0, 0, 0);
        checkOutput("draw_latency_plot", 32'(pix.plot), 0);
        checkRaster("draw0", 0, 3'b110, 0);
        step();
        checkOutput("draw0_end_plot", 32'(pix.plot), 0);

        $display("[TB] three ticks then the fourth");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 0, 0);
            step();
            applyStimulus(0, 0, 0, 0);
            step();
            checkOutput("three_ticks_plot", 32'(pix.plot), 0);
        end
        repeat (5) step();
        checkOutput("three_ticks_idle_plot", 32'(pix.plot), 0);
        applyStimulus(0, 1, 0, 0);
        step();
        applyStimulus(0, 0, 0, 0);
        checkRaster("erase0", 0, 3'b000, 0);
        step();
        checkOutput("update_gap", 32'(pix.plot), 0);
        checkRaster("draw1", 1, 3'b110, 0);
        step();
        checkOutput("draw1_end_plot", 32'(pix.plot), 0);

        $display("[TB] noise during erase/draw");
        applyStimulus(0, 1, 0, 0);
        repeat (4) step();
        applyStimulus(0, 0, 0, 0);
        checkRaster("erase1_noise", 1, 3'b000, 1);
        step();
        checkOutput("noise_update_gap", 32'(pix.plot), 0);
        checkRaster("draw2_noise", 2, 3'b110, 1);
        step();
        checkOutput("noise_wait_plot", 32'(pix.plot), 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 0, 0);
            step();
            applyStimulus(0, 0, 0, 0);
            step();
            checkOutput("no_queued_ticks_plot", 32'(pix.plot), 0);
        end

        $display("[TB] collision with simultaneous tick");
        applyStimulus(0, 1, 1, 0);
        step();
        applyStimulus(0, 0, 1, 0);
        checkOutput("lose_done", 32'(done), 1);
        checkOutput("lose_lose", 32'(lose), 1);
        checkOutput("lose_win", 32'(win), 0);
        for (int i = 0; i < 100; i++) begin
            applyStimulus(i == 50, 1, 1, 0);
            step();
            applyStimulus(0, 0, 1, 0);
            step();
            checkOutput("lose_no_plot", 32'(pix.plot), 0);
        end
        checkOutput("lose_held", 32'(lose), 1);

        $display("[TB] reset mid-draw");
        applyStimulus(0, 0, 0, 0);
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        step();
        applyStimulus(1, 0, 0, 0);
        step();
        applyStimulus(0, 0, 0, 0);
        for (int k = 0; k < 8; k++) step();
        checkOutput("pix7_plot", 32'(pix.plot), 1);
        checkOutput("pix7_x", 32'(pix.x_coord), 3);
        checkOutput("pix7_y", 32'(pix.y_coord), 61);
        #2 resetn = 1'b0;
        #1 checkReset("async_reset");
        step();
        resetn = 1'b1;
        step();
        checkOutput("post_reset_idle_plot", 32'(pix.plot), 0);
        applyStimulus(1, 0, 0, 0);
        step();
        applyStimulus(0, 0, 0, 0);
        checkRaster("redraw", 0, 3'b110, 0);
        step();

        $display("[TB] run to the right edge");
        for (int m = 1; m <= 154; m++) doMove(m - 1, m, 0);
        doMove(154, 155, 1);
        doMove(155, 156, 1);
        doMove(156, 156, 1);
        checkOutput("edge_no_win_yet", 32'(win), 0);
        applyStimulus(0, 0, 0, 1);
        step();
        checkOutput("win_done", 32'(done), 1);
        checkOutput("win_win", 32'(win), 1);
        checkOutput("win_lose", 32'(lose), 0);
        applyStimulus(0, 1, 0, 1);
        repeat (10) step();
        checkOutput("win_no_plot", 32'(pix.plot), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
